// File: rtl/pipe_rr_arbiter.sv
// Round-robin arbiter that merges N_REQ valid/ready producers into one registered
// output stage. A grant is held for a whole burst and each beat is tagged with its source.
`timescale 1ns/1ps
module pipe_rr_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8,
  localparam int SRC_W = $clog2(N_REQ)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        in_valid,
  output logic [N_REQ-1:0]        in_ready,
  input  logic [N_REQ*DATA_W-1:0] in_data,
  input  logic [N_REQ-1:0]        in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_last,
  output logic [SRC_W-1:0]        out_src,
  output logic                    o_dbg_state,
  output logic [SRC_W-1:0]        o_dbg_rr_ptr,
  output logic [SRC_W-1:0]        o_dbg_lock_idx
);

  // Handshake: a beat moves on a rising edge when valid and ready are both high;
  // a source holds data/last stable while valid=1 and ready=0.
  typedef enum logic {ST_IDLE = 1'b0, ST_LOCK = 1'b1} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [SRC_W-1:0]  r_rr_ptr;
  logic [SRC_W-1:0]  w_rr_ptr_next;
  logic [SRC_W-1:0]  r_lock_idx;
  logic [SRC_W-1:0]  w_lock_idx_next;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_last;
  logic [SRC_W-1:0]  r_out_src;

  logic              w_open;
  logic              w_found;
  logic              w_accept;
  logic [SRC_W-1:0]  w_gidx;
  logic [N_REQ-1:0]  w_grant;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_sel_last;

  assign w_open   = out_ready | ~r_out_valid;
  assign w_accept = w_open & w_found;
  assign in_ready = {N_REQ{w_open}} & w_grant;

  // Grant is a function of state and in_valid only, never of in_ready.
  always_comb begin
    int               idx;
    logic [SRC_W-1:0] cand;
    w_grant = '0;
    w_gidx  = '0;
    w_found = 1'b0;
    idx     = 0;
    cand    = '0;
    if (r_state == ST_LOCK) begin
      w_gidx              = r_lock_idx;
      w_found             = in_valid[r_lock_idx];
      w_grant[r_lock_idx] = in_valid[r_lock_idx];
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        idx = int'(r_rr_ptr) + k;
        if (idx >= N_REQ) idx = idx - N_REQ;
        cand = SRC_W'(idx);
        if (!w_found && in_valid[cand]) begin
          w_found       = 1'b1;
          w_gidx        = cand;
          w_grant[cand] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_sel_data = '0;
    w_sel_last = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gidx == SRC_W'(i)) begin
        w_sel_data = in_data[i*DATA_W +: DATA_W];
        w_sel_last = in_last[i];
      end
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_rr_ptr_next   = r_rr_ptr;
    w_lock_idx_next = r_lock_idx;
    if (w_accept) begin
      if (w_sel_last) begin
        w_state_next  = ST_IDLE;
        // Explicit wrap keeps non-power-of-2 N_REQ from producing an out-of-range index.
        w_rr_ptr_next = (w_gidx == SRC_W'(N_REQ - 1)) ? '0 : w_gidx + SRC_W'(1);
      end else begin
        w_state_next    = ST_LOCK;
        w_lock_idx_next = w_gidx;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_lock_idx  <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_src   <= '0;
    end else begin
      r_state    <= w_state_next;
      r_rr_ptr   <= w_rr_ptr_next;
      r_lock_idx <= w_lock_idx_next;
      if (w_open) begin
        r_out_valid <= w_accept;
        if (w_accept) begin
          r_out_data <= w_sel_data;
          r_out_last <= w_sel_last;
          r_out_src  <= w_gidx;
        end
      end
    end
  end

  assign out_valid      = r_out_valid;
  assign out_data       = r_out_data;
  assign out_last       = r_out_last;
  assign out_src        = r_out_src;
  assign o_dbg_state    = (r_state == ST_LOCK);
  assign o_dbg_rr_ptr   = r_rr_ptr;
  assign o_dbg_lock_idx = r_lock_idx;

endmodule

// File: tb/tb_pipe_rr_arbiter.sv
// Directed bench for pipe_rr_arbiter: a 4-requester and a 3-requester instance,
// expected beats queued at issue time and checked by a monitor as they leave the stage.
`timescale 1ns/1ps
module tb_pipe_rr_arbiter;

  logic        clock;
  logic        reset;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [31:0] in_data;
  logic [3:0]  in_last;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic [1:0]  out_src;
  logic        dbg_state;
  logic [1:0]  dbg_rr;
  logic [1:0]  dbg_lock;

  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic [23:0] in_data3;
  logic [2:0]  in_last3;
  logic        out_valid3;
  logic        out_ready3;
  logic [7:0]  out_data3;
  logic        out_last3;
  logic [1:0]  out_src3;
  logic        dbg_state3;
  logic [1:0]  dbg_rr3;
  logic [1:0]  dbg_lock3;

  logic [10:0] exp_q[$];
  logic [10:0] exp3_q[$];
  int          n_checks;
  int          n_fail;

  pipe_rr_arbiter #(.N_REQ(4), .DATA_W(8)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_src(out_src),
    .o_dbg_state(dbg_state), .o_dbg_rr_ptr(dbg_rr), .o_dbg_lock_idx(dbg_lock)
  );

  pipe_rr_arbiter #(.N_REQ(3), .DATA_W(8)) dut3 (
    .clock(clock), .reset(reset),
    .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3), .in_last(in_last3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
    .out_last(out_last3), .out_src(out_src3),
    .o_dbg_state(dbg_state3), .o_dbg_rr_ptr(dbg_rr3), .o_dbg_lock_idx(dbg_lock3)
  );

  // clock/reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [10:0] mk(input logic [1:0] s, input logic l, input logic [7:0] d);
    return {s, l, d};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input logic [1:0] i, input logic v, input logic [7:0] d, input logic l);
    in_valid[i]          = v;
    in_data[{i, 3'b000} +: 8] = d;
    in_last[i]           = l;
  endtask

  task automatic set_req3(input logic [1:0] i, input logic v, input logic [7:0] d, input logic l);
    in_valid3[i]           = v;
    in_data3[{i, 3'b000} +: 8] = d;
    in_last3[i]            = l;
  endtask

  task automatic idle_all();
    in_valid  = '0;
    in_valid3 = '0;
    tick();
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    reset      = 1'b1;
    in_valid   = '0;
    in_data    = '0;
    in_last    = '0;
    out_ready  = 1'b1;
    in_valid3  = '0;
    in_data3   = '0;
    in_last3   = '0;
    out_ready3 = 1'b1;

    // monitor and watchdog
    fork
      forever begin
        @(negedge clock);
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL beat4: unexpected beat src %0d data %0h", out_src, out_data);
          end else chk("beat4", {21'd0, out_src, out_last, out_data}, {21'd0, exp_q.pop_front()});
        end
        if (out_valid3 === 1'b1 && out_ready3 === 1'b1) begin
          if (exp3_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL beat3: unexpected beat src %0d data %0h", out_src3, out_data3);
          end else chk("beat3", {21'd0, out_src3, out_last3, out_data3}, {21'd0, exp3_q.pop_front()});
        end
      end
      begin
        #200000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: test did not complete within time limit");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
      end
    join_none

    tick();
    tick();
    reset = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_src", out_src, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_state", dbg_state, 0);
    chk("rst_rr_ptr", dbg_rr, 0);
    chk("rst_lock_idx", dbg_lock, 0);

    // all four valid, single-beat bursts: 0,1,2,3,0,1
    for (int i = 0; i < 4; i++) set_req(2'(i), 1'b1, 8'hA0 + 8'(i), 1'b1);
    exp_q.push_back(mk(2'd0, 1'b1, 8'hA0));
    exp_q.push_back(mk(2'd1, 1'b1, 8'hA1));
    exp_q.push_back(mk(2'd2, 1'b1, 8'hA2));
    exp_q.push_back(mk(2'd3, 1'b1, 8'hA3));
    exp_q.push_back(mk(2'd0, 1'b1, 8'hA0));
    exp_q.push_back(mk(2'd1, 1'b1, 8'hA1));
    repeat (6) begin
      tick();
      chk("t1_out_valid", out_valid, 1);
    end
    idle_all();
    chk("t1_rr_ptr", dbg_rr, 2);

    // move rr_ptr to 1 with one beat from req0
    set_req(2'd0, 1'b1, 8'h5A, 1'b1);
    exp_q.push_back(mk(2'd0, 1'b1, 8'h5A));
    tick();
    idle_all();

    // req1 3-beat burst against req0/req2
    set_req(2'd0, 1'b1, 8'h50, 1'b1);
    set_req(2'd2, 1'b1, 8'h52, 1'b1);
    set_req(2'd1, 1'b1, 8'h11, 1'b0);
    exp_q.push_back(mk(2'd1, 1'b0, 8'h11));
    exp_q.push_back(mk(2'd1, 1'b0, 8'h12));
    exp_q.push_back(mk(2'd1, 1'b1, 8'h13));
    exp_q.push_back(mk(2'd2, 1'b1, 8'h52));
    exp_q.push_back(mk(2'd0, 1'b1, 8'h50));
    #1 chk("t2_ready_b1", in_ready, 4'b0010);
    tick();
    set_req(2'd1, 1'b1, 8'h12, 1'b0);
    #1 chk("t2_ready_b2", in_ready, 4'b0010);
    chk("t2_state_lock", dbg_state, 1);
    chk("t2_lock_idx", dbg_lock, 1);
    tick();
    set_req(2'd1, 1'b1, 8'h13, 1'b1);
    #1 chk("t2_ready_b3", in_ready, 4'b0010);
    tick();
    set_req(2'd1, 1'b0, 8'h00, 1'b0);
    #1 chk("t2_ready_req2", in_ready, 4'b0100);
    tick();
    chk("t2_ready_req0", in_ready, 4'b0001);
    tick();
    idle_all();

    // req1 locked, drops valid for 2 cycles while req3 waits
    set_req(2'd1, 1'b1, 8'h21, 1'b0);
    set_req(2'd3, 1'b1, 8'h73, 1'b1);
    exp_q.push_back(mk(2'd1, 1'b0, 8'h21));
    exp_q.push_back(mk(2'd1, 1'b1, 8'h22));
    exp_q.push_back(mk(2'd3, 1'b1, 8'h73));
    #1 chk("t3_ready_b1", in_ready, 4'b0010);
    tick();
    set_req(2'd1, 1'b0, 8'h21, 1'b0);
    #1 chk("t3_ready_gap", in_ready, 4'b0000);
    repeat (2) begin
      tick();
      chk("t3_bubble_valid", out_valid, 0);
      chk("t3_bubble_ready", in_ready, 4'b0000);
      chk("t3_bubble_state", dbg_state, 1);
    end
    set_req(2'd1, 1'b1, 8'h22, 1'b1);
    #1 chk("t3_ready_resume", in_ready, 4'b0010);
    tick();
    set_req(2'd1, 1'b0, 8'h00, 1'b0);
    #1 chk("t3_ready_req3", in_ready, 4'b1000);
    tick();
    idle_all();

    // downstream stall for 5 cycles
    set_req(2'd0, 1'b1, 8'h40, 1'b1);
    set_req(2'd2, 1'b1, 8'h42, 1'b1);
    exp_q.push_back(mk(2'd0, 1'b1, 8'h40));
    exp_q.push_back(mk(2'd2, 1'b1, 8'h42));
    tick();
    set_req(2'd0, 1'b0, 8'h00, 1'b0);
    out_ready = 1'b0;
    repeat (5) begin
      tick();
      chk("t4_hold_valid", out_valid, 1);
      chk("t4_hold_data", out_data, 8'h40);
      chk("t4_hold_src", out_src, 0);
      chk("t4_hold_last", out_last, 1);
      chk("t4_hold_ready", in_ready, 4'b0000);
    end
    chk("t4_hold_rr", dbg_rr, 1);
    out_ready = 1'b1;
    #1 chk("t4_release_ready", in_ready, 4'b0100);
    tick();
    chk("t4_next_valid", out_valid, 1);
    chk("t4_next_src", out_src, 2);
    chk("t4_next_data", out_data, 8'h42);
    idle_all();

    // reset during 2nd beat of a req2 burst
    set_req(2'd2, 1'b1, 8'hC1, 1'b0);
    exp_q.push_back(mk(2'd2, 1'b0, 8'hC1));
    tick();
    set_req(2'd2, 1'b1, 8'hC2, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_out_valid", out_valid, 0);
    chk("t5_out_data", out_data, 0);
    chk("t5_out_src", out_src, 0);
    chk("t5_out_last", out_last, 0);
    chk("t5_state", dbg_state, 0);
    chk("t5_rr_ptr", dbg_rr, 0);
    chk("t5_lock_idx", dbg_lock, 0);
    set_req(2'd2, 1'b1, 8'hD2, 1'b1);
    set_req(2'd0, 1'b1, 8'hE0, 1'b1);
    exp_q.push_back(mk(2'd0, 1'b1, 8'hE0));
    exp_q.push_back(mk(2'd2, 1'b1, 8'hD2));
    #1 chk("t5_ready_req0", in_ready, 4'b0001);
    tick();
    set_req(2'd0, 1'b0, 8'h00, 1'b0);
    tick();
    idle_all();

    // N_REQ=3: wrap from req2 back to req0
    set_req3(2'd2, 1'b1, 8'h32, 1'b1);
    exp3_q.push_back(mk(2'd2, 1'b1, 8'h32));
    tick();
    chk("t6_rr_wrap", dbg_rr3, 0);
    for (int i = 0; i < 3; i++) set_req3(2'(i), 1'b1, 8'h30 + 8'(i), 1'b1);
    exp3_q.push_back(mk(2'd0, 1'b1, 8'h30));
    exp3_q.push_back(mk(2'd1, 1'b1, 8'h31));
    exp3_q.push_back(mk(2'd2, 1'b1, 8'h32));
    exp3_q.push_back(mk(2'd0, 1'b1, 8'h30));
    #1 chk("t6_ready_req0", in_ready3, 3'b001);
    tick();
    chk("t6_src0", out_src3, 0);
    tick();
    tick();
    chk("t6_rr_wrap2", dbg_rr3, 0);
    tick();
    chk("t6_src_wrapped", out_src3, 0);
    idle_all();
    chk("t6_rr_final", dbg_rr3, 1);

    tick();
    tick();
    chk("queue4_drained", exp_q.size(), 0);
    chk("queue3_drained", exp3_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
